// File: rtl/uart_echo_checker_pkg.sv
// Shared state encoding for the UART echo checker.
package uart_echo_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/uart_echo_checker_sat_counter.sv
// Status counter that saturates at all-ones instead of wrapping; clear has priority.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && (value != {WIDTH{1'b1}})) begin
      value <= value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_echo_checker.sv
// Stop-and-wait echo checker: sends an incrementing byte pattern to UART TX and
// checks each byte returned on UART RX, counting passes, errors, timeouts and strays.
module uart_echo_checker
  import uart_echo_checker_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 260417
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [CNT_WIDTH-1:0]  count,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  pass_count,
  output logic [CNT_WIDTH-1:0]  error_count,
  output logic [CNT_WIDTH-1:0]  timeout_count,
  output logic [CNT_WIDTH-1:0]  stray_count,
  output logic [DATA_WIDTH-1:0] last_rx
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] cur_q, cur_d;
  logic [CNT_WIDTH-1:0]  sent_q, sent_d, sent_inc;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tready_q;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] last_rx_q, last_rx_d;

  logic m_hs, s_hs, timed_out, finish;
  logic clr_cnt, inc_pass, inc_error, inc_timeout, inc_stray;

  assign m_hs      = tvalid_q & m_axis_tready;
  assign s_hs      = s_axis_tvalid & tready_q;
  assign timed_out = (timer_q == TIMER_LAST);
  assign sent_inc  = sent_q + CNT_WIDTH'(1);
  assign finish    = stop || ((count_q != '0) && (sent_inc == count_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cur_q     <= '0;
      sent_q    <= '0;
      count_q   <= '0;
      timer_q   <= '0;
      tvalid_q  <= 1'b0;
      tready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      last_rx_q <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      sent_q    <= sent_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
      tvalid_q  <= tvalid_d;
      tready_q  <= 1'b1;
      busy_q    <= busy_d;
      done_q    <= done_d;
      last_rx_q <= last_rx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    sent_d      = sent_q;
    count_d     = count_q;
    timer_d     = timer_q;
    tvalid_d    = tvalid_q;
    busy_d      = busy_q;
    done_d      = done_q;
    last_rx_d   = last_rx_q;
    clr_cnt     = 1'b0;
    inc_pass    = 1'b0;
    inc_error   = 1'b0;
    inc_timeout = 1'b0;
    inc_stray   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        inc_stray = s_hs;
        if (start) begin
          count_d   = count;
          cur_d     = seed;
          sent_d    = '0;
          clr_cnt   = 1'b1;
          last_rx_d = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          tvalid_d  = 1'b1;
          state_d   = ST_SEND;
        end
      end

      ST_SEND: begin
        inc_stray = s_hs;
        if (m_hs) begin
          tvalid_d = 1'b0;
          timer_d  = '0;
          state_d  = ST_WAIT;
        end
      end

      ST_WAIT: begin
        timer_d = timer_q + TIMER_W'(1);
        // A byte arriving on the timeout cycle takes precedence over the timeout.
        if (s_hs || timed_out) begin
          if (s_hs) begin
            last_rx_d = s_axis_tdata;
            inc_pass  = (s_axis_tdata == cur_q);
            inc_error = (s_axis_tdata != cur_q);
          end else begin
            inc_timeout = 1'b1;
          end
          sent_d = sent_inc;
          if (finish) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            cur_d    = cur_q + DATA_WIDTH'(1);
            tvalid_d = 1'b1;
            state_d  = ST_SEND;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_pass_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clr_cnt), .inc(inc_pass), .value(pass_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_error_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clr_cnt), .inc(inc_error), .value(error_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_timeout_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clr_cnt), .inc(inc_timeout), .value(timeout_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stray_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clr_cnt), .inc(inc_stray), .value(stray_count)
  );

  assign m_axis_tdata  = cur_q;
  assign m_axis_tvalid = tvalid_q;
  assign s_axis_tready = tready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign last_rx       = last_rx_q;

endmodule

// File: tb/tb_uart_echo_checker.sv
// Directed bench for uart_echo_checker: a bench-side echo responder with per-byte
// corrupt/drop control and a scoreboard of the expected transmit pattern.
module tb_uart_echo_checker;

  localparam int DW = 8;
  localparam int CW = 16;
  localparam int TO = 16;

  localparam int M_OK      = 0;
  localparam int M_CORRUPT = 1;
  localparam int M_DROP    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          stop;
  logic [CW-1:0] count;
  logic [DW-1:0] seed;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          busy;
  logic          done;
  logic [CW-1:0] pass_count;
  logic [CW-1:0] error_count;
  logic [CW-1:0] timeout_count;
  logic [CW-1:0] stray_count;
  logic [DW-1:0] last_rx;

  uart_echo_checker #(
    .DATA_WIDTH    (DW),
    .CNT_WIDTH     (CW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .count        (count),
    .seed         (seed),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .busy         (busy),
    .done         (done),
    .pass_count   (pass_count),
    .error_count  (error_count),
    .timeout_count(timeout_count),
    .stray_count  (stray_count),
    .last_rx      (last_rx)
  );

  always #5 clk = ~clk;

  int            n_assert = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  logic [DW-1:0] exp_q[$];
  int            mode_arr[8];
  int            hs_cyc[8];
  int            hs_idx     = 0;
  logic          echo_pend  = 1'b0;
  int            echo_tmr   = 0;
  int            echo_delay = 3;
  logic [DW-1:0] echo_data  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, then act as the echo responder after it.
  task automatic tick();
    logic          hs;
    logic [DW-1:0] txd;
    int            mode;
    hs  = m_axis_tvalid & m_axis_tready;
    txd = m_axis_tdata;
    @(posedge clk);
    #1;
    cyc++;
    s_axis_tvalid = 1'b0;
    if (hs) begin
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL tx_unexpected: observed byte %02h expected no transmit", txd);
      end
      if (exp_q.size() != 0) check("tx_byte", 32'(txd), 32'(exp_q.pop_front()));
      mode = (hs_idx < 8) ? mode_arr[hs_idx] : M_OK;
      if (hs_idx < 8) hs_cyc[hs_idx] = cyc;
      hs_idx++;
      if (mode != M_DROP) begin
        echo_pend = 1'b1;
        echo_tmr  = echo_delay - 1;
        echo_data = (mode == M_CORRUPT) ? (txd ^ 8'h01) : txd;
      end
    end else if (echo_pend) begin
      echo_tmr--;
    end
    if (echo_pend && echo_tmr == 0) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = echo_data;
      echo_pend     = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] s, input logic [CW-1:0] n, input int npush);
    logic [DW-1:0] b;
    b = s;
    for (int i = 0; i < npush; i++) begin
      exp_q.push_back(b);
      b = b + 8'd1;
    end
    for (int i = 0; i < 8; i++) mode_arr[i] = M_OK;
    hs_idx = 0;
    seed   = s;
    count  = n;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check("run_done", 32'(done), 32'(1));
  endtask

  task automatic checkOutput(input string tag, input int p, input int e, input int t, input int s,
                             input logic [DW-1:0] lr);
    check({tag, "_pass"},    32'(pass_count),    32'(p));
    check({tag, "_error"},   32'(error_count),   32'(e));
    check({tag, "_timeout"}, 32'(timeout_count), 32'(t));
    check({tag, "_stray"},   32'(stray_count),   32'(s));
    check({tag, "_last_rx"}, 32'(last_rx),       32'(lr));
    check({tag, "_busy"},    32'(busy),          32'(0));
    check({tag, "_queue"},   32'(exp_q.size()),  32'(0));
  endtask

  initial begin
    int n;
    int t0;
    rst_n         = 1'b0;
    start         = 1'b0;
    stop          = 1'b0;
    count         = '0;
    seed          = '0;
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    for (int i = 0; i < 8; i++) begin
      mode_arr[i] = M_OK;
      hs_cyc[i]   = 0;
    end

    #1;
    check("rst_tvalid", 32'(m_axis_tvalid), 32'(0));
    check("rst_tready", 32'(s_axis_tready), 32'(0));
    check("rst_busy",   32'(busy),          32'(0));
    check("rst_done",   32'(done),          32'(0));
    tick();
    tick();
    rst_n = 1'b1;
    check("rel_tready_low", 32'(s_axis_tready), 32'(0));
    tick();
    check("rel_tready_high", 32'(s_axis_tready), 32'(1));

    $display("[TB] perfect loopback");
    echo_delay = 3;
    applyStimulus(8'h41, 16'd5, 5);
    check("start_tvalid", 32'(m_axis_tvalid), 32'(1));
    check("start_busy",   32'(busy),          32'(1));
    check("start_tdata",  32'(m_axis_tdata),  32'(8'h41));
    wait_done(300);
    checkOutput("loop", 5, 0, 0, 0, 8'h45);

    $display("[TB] corruption with wrap");
    applyStimulus(8'hFE, 16'd4, 4);
    mode_arr[2] = M_CORRUPT;
    wait_done(300);
    checkOutput("corrupt", 3, 1, 0, 0, 8'h01);

    $display("[TB] timeout");
    applyStimulus(8'h10, 16'd3, 3);
    mode_arr[1] = M_DROP;
    n = 0;
    while (timeout_count == '0 && n < 200) begin
      tick();
      n++;
    end
    check("timeout_seen", 32'(timeout_count), 32'(1));
    check("timeout_latency", 32'(cyc - hs_cyc[1]), 32'(TO));
    wait_done(300);
    checkOutput("timeout", 2, 0, 1, 0, 8'h12);

    $display("[TB] backpressure and stop");
    m_axis_tready = 1'b0;
    applyStimulus(8'h80, 16'd0, 1);
    for (int i = 0; i < 10; i++) begin
      check("stall_tvalid", 32'(m_axis_tvalid), 32'(1));
      check("stall_tdata",  32'(m_axis_tdata),  32'(8'h80));
      if (i == 4) stop = 1'b1;
      tick();
    end
    m_axis_tready = 1'b1;
    wait_done(300);
    stop = 1'b0;
    check("stop_tvalid", 32'(m_axis_tvalid), 32'(0));
    checkOutput("stop", 1, 0, 0, 0, 8'h80);

    $display("[TB] reset mid-run");
    applyStimulus(8'h30, 16'd3, 3);
    n = 0;
    while (pass_count == '0 && n < 100) begin
      tick();
      n++;
    end
    check("mid_pass_before", 32'(pass_count), 32'(1));
    m_axis_tready = 1'b0;
    tick();
    tick();
    check("mid_tvalid_before", 32'(m_axis_tvalid), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_tvalid_after", 32'(m_axis_tvalid), 32'(0));
    check("mid_pass_after",   32'(pass_count),    32'(0));
    check("mid_busy_after",   32'(busy),          32'(0));
    check("mid_tready_after", 32'(s_axis_tready), 32'(0));
    exp_q.delete();
    echo_pend     = 1'b0;
    m_axis_tready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] strays in idle, then echo on the timeout cycle");
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'hAA;
    tick();
    tick();
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'hBB;
    tick();
    tick();
    check("idle_strays", 32'(stray_count), 32'(2));
    echo_delay = TO;
    applyStimulus(8'h55, 16'd1, 1);
    check("strays_cleared", 32'(stray_count), 32'(0));
    t0 = cyc;
    wait_done(300);
    check("edge_run_cycles", 32'(cyc - t0), 32'(TO + 1));
    checkOutput("edge", 1, 0, 0, 0, 8'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
